// File: rtl/sprite_animator.sv
// sprite_animator: positioned, scaled, animated sprite renderer for the
// 640x480 VGA path. Maps DrawX/DrawY into an external synchronous sprite ROM
// holding FRAMES stacked images, steps frames on frame_start ticks, and
// composites palette RGB over a background RGB.
// Pixel pipeline: S1 (rom_address) -> ROM read -> S2 (pal_idx) -> RGB, so RGB
// for a pixel appears three cycles after its rom_address.
// Optional feature macro: SPRITE_TRANSPARENCY_EN (texels equal to TRANSP_IDX
// show the background instead of their palette colour).
module sprite_animator #(
  parameter int SPR_W       = 92,
  parameter int SPR_H       = 120,
  parameter int FRAMES      = 4,
  parameter int ADDR_W      = 16,
  parameter int FRAME_TICKS = 8
`ifdef SPRITE_TRANSPARENCY_EN
  , parameter int TRANSP_IDX = 0
`endif
) (
  input  logic                       vga_clk,
  input  logic                       reset_n,
  input  logic [9:0]                 DrawX,
  input  logic [9:0]                 DrawY,
  input  logic                       blank,
  input  logic                       frame_start,
  input  logic [9:0]                 pos_x,
  input  logic [9:0]                 pos_y,
  input  logic [1:0]                 scale,
  input  logic                       flip_x,
  input  logic                       start,
  input  logic                       loop,
  output logic [ADDR_W-1:0]          rom_address,
  input  logic [3:0]                 rom_q,
  output logic [3:0]                 pal_idx,
  input  logic [3:0]                 pal_r,
  input  logic [3:0]                 pal_g,
  input  logic [3:0]                 pal_b,
  input  logic [3:0]                 bg_r,
  input  logic [3:0]                 bg_g,
  input  logic [3:0]                 bg_b,
  output logic [3:0]                 red,
  output logic [3:0]                 green,
  output logic [3:0]                 blue,
  output logic [$clog2(FRAMES)-1:0]  frame_idx,
  output logic                       busy,
  output logic                       anim_done
);

  localparam int FW       = $clog2(FRAMES);
  localparam int TW       = $clog2(FRAME_TICKS + 1);
  localparam int FRAME_SZ = SPR_W * SPR_H;
  localparam logic [FW-1:0] LAST_FRAME = FW'(FRAMES - 1);
  localparam logic [TW-1:0] LAST_TICK  = TW'(FRAME_TICKS - 1);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PLAY = 2'd1, ST_HOLD = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [FW-1:0]     frame_q, frame_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic              done_q, done_d, busy_q;

  logic [9:0]        sx_q, sy_q;
  logic [1:0]        sc_q;
  logic              flip_q;

  logic [11:0]       px_s, py_s, lx_raw_s, lx_s, ly_s;
  logic              hit_s, opaque_s;
  logic [ADDR_W-1:0] addr_s, rom_address_q, rom_address_d;
  logic              hit1_q, blank1_q, hit1b_q, blank1b_q, hit2_q, blank2_q;
  logic [11:0]       bg1_q, bg1b_q, bg2_q, rgb_q, rgb_d;
  logic [3:0]        pal_idx_q;

  // Shadow placement registers: only frame_start may move/rescale the sprite.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      sx_q   <= 10'd0;
      sy_q   <= 10'd0;
      sc_q   <= 2'd0;
      flip_q <= 1'b0;
    end else if (frame_start) begin
      sx_q   <= pos_x;
      sy_q   <= pos_y;
      sc_q   <= (scale == 2'd3) ? 2'd2 : scale;
      flip_q <= flip_x;
    end
  end

  // Hit test and texel address; subtractions are 12-bit so left/top misses never alias.
  always_comb begin
    px_s     = {2'b00, DrawX} - {2'b00, sx_q};
    py_s     = {2'b00, DrawY} - {2'b00, sy_q};
    lx_raw_s = px_s >> sc_q;
    ly_s     = py_s >> sc_q;
    hit_s    = (DrawX >= sx_q) && (DrawY >= sy_q) &&
               (lx_raw_s < 12'(SPR_W)) && (ly_s < 12'(SPR_H));
    if (flip_q) begin
      lx_s = 12'(SPR_W - 1) - lx_raw_s;
    end else begin
      lx_s = lx_raw_s;
    end
    addr_s = ADDR_W'(frame_q) * ADDR_W'(FRAME_SZ) +
             ADDR_W'(ly_s) * ADDR_W'(SPR_W) + ADDR_W'(lx_s);
    if (hit_s) begin
      rom_address_d = addr_s;
    end else begin
      rom_address_d = rom_address_q;
    end
  end

  // Texel opacity, judged on the ROM data as it enters S2.
  always_comb begin
`ifdef SPRITE_TRANSPARENCY_EN
    opaque_s = (rom_q != 4'(TRANSP_IDX));
`else
    opaque_s = 1'b1;
`endif
  end

  // Final colour mux: blanking forces black, otherwise sprite over background.
  always_comb begin
    if (!blank2_q) begin
      rgb_d = 12'h000;
    end else if (hit2_q) begin
      rgb_d = {pal_r, pal_g, pal_b};
    end else begin
      rgb_d = bg2_q;
    end
  end

  // Pixel pipeline: S1, ROM-latency alignment stage, S2, registered RGB.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_address_q <= {ADDR_W{1'b0}};
      hit1_q        <= 1'b0;
      blank1_q      <= 1'b0;
      bg1_q         <= 12'h000;
      hit1b_q       <= 1'b0;
      blank1b_q     <= 1'b0;
      bg1b_q        <= 12'h000;
      pal_idx_q     <= 4'd0;
      hit2_q        <= 1'b0;
      blank2_q      <= 1'b0;
      bg2_q         <= 12'h000;
      rgb_q         <= 12'h000;
    end else begin
      rom_address_q <= rom_address_d;
      hit1_q        <= hit_s;
      blank1_q      <= blank;
      bg1_q         <= {bg_r, bg_g, bg_b};
      hit1b_q       <= hit1_q;
      blank1b_q     <= blank1_q;
      bg1b_q        <= bg1_q;
      pal_idx_q     <= rom_q;
      hit2_q        <= hit1b_q & opaque_s;
      blank2_q      <= blank1b_q;
      bg2_q         <= bg1b_q;
      rgb_q         <= rgb_d;
    end
  end

  // Animation FSM next state: start always wins, frames only move on frame_start.
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    tick_d  = tick_q;
    done_d  = 1'b0;
    if (start) begin
      state_d = ST_PLAY;
      frame_d = {FW{1'b0}};
      tick_d  = {TW{1'b0}};
    end else begin
      case (state_q)
        ST_PLAY: begin
          if (frame_start) begin
            if (tick_q == LAST_TICK) begin
              tick_d = {TW{1'b0}};
              if (frame_q == LAST_FRAME) begin
                if (loop) begin
                  frame_d = {FW{1'b0}};
                end else begin
                  state_d = ST_HOLD;
                  done_d  = 1'b1;
                end
              end else begin
                frame_d = frame_q + FW'(1);
                // Without looping the animation finishes on entering the last frame.
                if ((frame_d == LAST_FRAME) && !loop) begin
                  state_d = ST_HOLD;
                  done_d  = 1'b1;
                end else begin
                  state_d = ST_PLAY;
                end
              end
            end else begin
              tick_d = tick_q + TW'(1);
            end
          end else begin
            tick_d = tick_q;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // Animation FSM registers; busy/anim_done are registered from next state.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      frame_q <= {FW{1'b0}};
      tick_q  <= {TW{1'b0}};
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
      busy_q  <= (state_d == ST_PLAY);
    end
  end

  assign rom_address = rom_address_q;
  assign pal_idx     = pal_idx_q;
  assign red         = rgb_q[11:8];
  assign green       = rgb_q[7:4];
  assign blue        = rgb_q[3:0];
  assign frame_idx   = frame_q;
  assign busy        = busy_q;
  assign anim_done   = done_q;

endmodule
